alu_wb_stage: RTL and testbench
===============================

# alu_wb_stage

Buffered writeback stage directly downstream of the combinational 64-bit ALU. It accepts one ALU result per cycle with a destination register index and queues it in a small FIFO. It presents results to the register-file write port under a valid/ready handshake. It also records ALU errors (divide-by-zero) in a sticky status register and gives the upstream issue logic a pending-destination hazard check.

## Interface
- `DATA_W`, 64: result width; matches the ALU `res`.
- `REG_AW`, 5: destination register index width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: ALU result valid this cycle.
- `in_ready` out 1: stage can accept; equals `count != DEPTH`; no combinational path from `wb_ready`.
- `in_res` in DATA_W: ALU `res`.
- `in_error` in 1: ALU `error`.
- `in_rd` in REG_AW: destination register.
- `in_wen` in 1: result must be written back (0 = compare/pass ops with no destination).
- `wb_valid` out 1: head entry valid for writeback.
- `wb_ready` in 1: register file accepts this cycle.
- `wb_data` out DATA_W: head result.
- `wb_rd` out REG_AW: head destination.
- `hz_rd` in REG_AW: register index queried by issue logic.
- `hz_hit` out 1: combinational; 1 if any valid FIFO entry has `rd == hz_rd`.
- `err_sticky` out 1: an ALU error has been seen since reset/clear.
- `err_rd` out REG_AW: destination of the first errored op since last clear.
- `err_clr` in 1: clears sticky error.
- `count` out $clog2(DEPTH)+1: entries held.

## Operation
- Accept occurs when `in_valid && in_ready`.
- Accept with `in_error=1`: entry is not queued. `err_sticky` becomes 1 next cycle. `err_rd` captures `in_rd` only if `err_sticky` was 0.
- Accept with `in_error=0, in_wen=0`: consumed and discarded; no queue change.
- Accept with `in_error=0, in_wen=1`: {`in_res`,`in_rd`} is pushed at the write pointer.
- Pop occurs when `wb_valid && wb_ready`; the read pointer advances.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is tracked separately, so full and empty are unambiguous.
- Push and pop in the same cycle: `count` is unchanged, both pointers advance. This is legal at full only when `in_ready` was already high, which at full it is not. Push at full is therefore impossible.
- `err_clr` and a new error in the same cycle: the error wins. `err_sticky` stays 1 and `err_rd` takes the new `in_rd`.
- `hz_hit` checks only valid entries, from the read pointer for `count` entries. Stale slots never hit.
- Reset mid-operation: all queued entries are discarded with no writeback. Pointers and count go to 0.

## Timing
- Reset values: `wb_valid`=0, `count`=0, `in_ready`=1, `err_sticky`=0, `err_rd`=0, `wb_data`=0, `wb_rd`=0, `hz_hit`=0.
- Latency: a result accepted at edge N is visible on `wb_*` after edge N (minimum 1 cycle).
- Throughput: 1 accept and 1 writeback per cycle sustained.
- `wb_data`/`wb_rd` are held stable while `wb_valid && !wb_ready`.
- `err_sticky` sets 1 cycle after the errored accept.

## Configuration
- `ALU_WB_BYPASS_EN` defined:
  - When the FIFO is empty, `in_valid && in_wen && !in_error` drives `wb_valid`/`wb_data`/`wb_rd` combinationally from the inputs.
  - If `wb_ready` is also 1 that cycle, the result is written with zero latency and not queued.
  - If `wb_ready` is 0, it is pushed normally.
  - `hz_hit` is unaffected by the bypass.
- Not defined: no bypass; latency is always ≥1 cycle and the `wb_*` outputs are purely registered/FIFO-read.

## Structure
- Package `alu_wb_pkg`:
  - `DATA_W`/`REG_AW` default constants.
  - Typedef `wb_entry_t` struct {data, rd}.
- Sub-module `wb_fifo`: storage array, pointers, count, full/empty, per-entry valid vector for hazard compare.
- Top level owns:
  - accept filtering;
  - error sticky logic;
  - bypass mux;
  - `hz_hit` reduction.

## Test plan
- Reset then single push: `in_res`=0x2A, `in_rd`=3, `wb_ready`=1 → `wb_valid`=1 with data 0x2A, rd 3 one cycle later (same cycle with `ALU_WB_BYPASS_EN`). `count` returns to 0.
- Fill: `wb_ready`=0, push 4 entries rd 1..4 → `in_ready`=0 at `count`=4. Release `wb_ready` → writebacks in order 1,2,3,4 across the pointer wrap.
- Error path: `in_error`=1, `in_rd`=7, then `in_error`=1, `in_rd`=9 → `err_sticky`=1, `err_rd`=7, no writeback. `err_clr` together with a new error rd 5 → `err_sticky`=1, `err_rd`=5.
- Hazard: queue rd 6 with `wb_ready`=0, `hz_rd`=6 → `hz_hit`=1. After the pop, `hz_hit`=0; a stale slot holding rd 6 never hits.
- Simultaneous push and pop at `count`=2 for 10 cycles → `count` stays 2 and data order is preserved.
- Assert `rst` with 3 entries queued → `wb_valid`=0 and `count`=0 immediately, with no writeback of old entries after release.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared constants and types for the ALU writeback stage.
package alu_wb_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int REG_AW_DEF = 5;
    localparam int DEPTH_DEF  = 4;

    // One queued writeback: result plus destination register.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [REG_AW_DEF-1:0] rd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback result queue: storage, wrapping pointers, explicit occupancy count,
// and a per-slot valid vector so the top level can run the hazard compare.
module wb_fifo
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic [REG_AW-1:0]        push_rd,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic [REG_AW-1:0]        head_rd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH-1:0]         ent_vld,
    output logic [DEPTH*REG_AW-1:0]  ent_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [REG_AW-1:0] mem_rd   [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;

    // Pointers wrap naturally at AW bits; count disambiguates full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr] <= push_data;
            mem_rd[wptr]   <= push_rd;
        end
    end

    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    // Head is forced to zero when empty so outputs are clean without resetting storage.
    assign head_data = empty ? '0 : mem_data[rptr];
    assign head_rd   = empty ? '0 : mem_rd[rptr];

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [AW-1:0] off;
        off     = '0;
        ent_vld = '0;
        ent_rd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rptr;
            ent_vld[i] = ({1'b0, off} < cnt);
            ent_rd[i*REG_AW +: REG_AW] = mem_rd[i];
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Buffered writeback stage behind the 64-bit ALU: accept filtering, result
// queue, sticky divide-by-zero status and pending-destination hazard check.
// Optional macro ALU_WB_BYPASS_EN: zero-latency writeback when the queue is empty.
module alu_wb_stage
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_res,
    input  logic                   in_error,
    input  logic [REG_AW-1:0]      in_rd,
    input  logic                   in_wen,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [DATA_W-1:0]      wb_data,
    output logic [REG_AW-1:0]      wb_rd,
    input  logic [REG_AW-1:0]      hz_rd,
    output logic                   hz_hit,
    output logic                   err_sticky,
    output logic [REG_AW-1:0]      err_rd,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] count
);

    logic                    accept;
    logic                    acc_err;
    logic                    acc_wb;
    logic                    push;
    logic                    pop;
    logic [DATA_W-1:0]       f_data;
    logic [REG_AW-1:0]       f_rd;
    logic                    f_full;
    logic                    f_empty;
    logic [DEPTH-1:0]        ent_vld;
    logic [DEPTH*REG_AW-1:0] ent_rd;

    // in_ready depends only on occupancy, never on wb_ready.
    assign in_ready = !f_full;
    assign accept   = in_valid && in_ready;
    assign acc_err  = accept && in_error;
    assign acc_wb   = accept && !in_error && in_wen;

`ifdef ALU_WB_BYPASS_EN
    logic bypass;
    // Empty queue lets a fresh result go straight to the write port.
    assign bypass   = f_empty && in_valid && in_wen && !in_error;
    assign wb_valid = !f_empty || bypass;
    assign wb_data  = bypass ? in_res : f_data;
    assign wb_rd    = bypass ? in_rd  : f_rd;
    assign push     = acc_wb && !(bypass && wb_ready);
    assign pop      = !f_empty && wb_ready;
`else
    assign wb_valid = !f_empty;
    assign wb_data  = f_data;
    assign wb_rd    = f_rd;
    assign push     = acc_wb;
    assign pop      = wb_valid && wb_ready;
`endif

    wb_fifo #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_res),
        .push_rd   (in_rd),
        .pop       (pop),
        .head_data (f_data),
        .head_rd   (f_rd),
        .count     (count),
        .full      (f_full),
        .empty     (f_empty),
        .ent_vld   (ent_vld),
        .ent_rd    (ent_rd)
    );

    // Sticky error: a new error beats a same-cycle clear and refreshes err_rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_rd     <= '0;
        end else if (acc_err) begin
            err_sticky <= 1'b1;
            if (!err_sticky || err_clr) err_rd <= in_rd;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    // Hazard reduction over live queue slots only; stale slots are masked.
    always_comb begin
        hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_rd[i*REG_AW +: REG_AW] == hz_rd)) hz_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage.
module tb_alu_wb_stage;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_res;
    logic              in_error;
    logic [REG_AW-1:0] in_rd;
    logic              in_wen;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [REG_AW-1:0] wb_rd;
    logic [REG_AW-1:0] hz_rd;
    logic              hz_hit;
    logic              err_sticky;
    logic [REG_AW-1:0] err_rd;
    logic              err_clr;
    logic [2:0]        count;

    int checks = 0;
    int passes = 0;

    alu_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .in_error   (in_error),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .hz_rd      (hz_rd),
        .hz_hit     (hz_hit),
        .err_sticky (err_sticky),
        .err_rd     (err_rd),
        .err_clr    (err_clr),
        .count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_error = 1'b0;
        in_wen   = 1'b0;
        in_res   = '0;
        in_rd    = '0;
        err_clr  = 1'b0;
    endtask

    task automatic push_in(input logic [DATA_W-1:0] d, input logic [REG_AW-1:0] r);
        in_valid = 1'b1;
        in_error = 1'b0;
        in_wen   = 1'b1;
        in_res   = d;
        in_rd    = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        wb_ready = 1'b0;
        hz_rd    = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid); else passes++;
        checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
        checks++; if (err_sticky !== 1'b0 || err_rd !== 5'd0) $display("FAIL reset_err: got %b/%0d want 0/0", err_sticky, err_rd); else passes++;
        checks++; if (wb_data !== 64'd0 || wb_rd !== 5'd0) $display("FAIL reset_wb_bus: got %h/%0d want 0/0", wb_data, wb_rd); else passes++;
        checks++; if (hz_hit !== 1'b0) $display("FAIL reset_hz_hit: got %b want 0", hz_hit); else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        push_in(64'h2A, 5'd3);
        wb_ready = 1'b1;
        #1;
`ifdef ALU_WB_BYPASS_EN
        checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h2A || wb_rd !== 5'd3) $display("FAIL single_bypass: got %b/%h/%0d want 1/2a/3", wb_valid, wb_data, wb_rd); else passes++;
        tick();
        drive_idle();
        checks++; if (count !== 3'd0) $display("FAIL single_count: got %0d want 0", count); else passes++;
`else
        checks++; if (wb_valid !== 1'b0) $display("FAIL single_pre_valid: got %b want 0", wb_valid); else passes++;
        tick();
        drive_idle();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h2A || wb_rd !== 5'd3) $display("FAIL single_head: got %b/%h/%0d want 1/2a/3", wb_valid, wb_data, wb_rd); else passes++;
        checks++; if (count !== 3'd1) $display("FAIL single_count1: got %0d want 1", count); else passes++;
        tick();
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0) $display("FAIL single_drain: got count %0d valid %b want 0/0", count, wb_valid); else passes++;
`endif
        wb_ready = 1'b0;
    endtask

    task automatic test_fill();
        wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_in(64'h100 + 64'(i), 5'(i));
            tick();
            checks++; if (count !== 3'(i)) $display("FAIL fill_count: got %0d want %0d", count, i); else passes++;
        end
        checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else passes++;
        push_in(64'h999, 5'd9);
        tick();
        checks++; if (count !== 3'd4) $display("FAIL fill_push_at_full: got %0d want 4", count); else passes++;
        drive_idle();
        wb_ready = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'(i) || wb_data !== 64'h100 + 64'(i)) $display("FAIL fill_order: got %b/%0d/%h want 1/%0d/%h", wb_valid, wb_rd, wb_data, i, 64'h100 + 64'(i)); else passes++;
            tick();
        end
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0) $display("FAIL fill_drained: got count %0d valid %b want 0/0", count, wb_valid); else passes++;
        wb_ready = 1'b0;
    endtask

    task automatic test_error();
        wb_ready = 1'b0;
        in_valid = 1'b1; in_error = 1'b1; in_wen = 1'b1; in_res = 64'hDEAD; in_rd = 5'd7;
        tick();
        checks++; if (err_sticky !== 1'b1 || err_rd !== 5'd7) $display("FAIL err_first: got %b/%0d want 1/7", err_sticky, err_rd); else passes++;
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0) $display("FAIL err_not_queued: got count %0d valid %b want 0/0", count, wb_valid); else passes++;
        in_rd = 5'd9;
        tick();
        checks++; if (err_sticky !== 1'b1 || err_rd !== 5'd7) $display("FAIL err_second_keeps: got %b/%0d want 1/7", err_sticky, err_rd); else passes++;
        err_clr = 1'b1; in_rd = 5'd5;
        tick();
        checks++; if (err_sticky !== 1'b1 || err_rd !== 5'd5) $display("FAIL err_clr_vs_new: got %b/%0d want 1/5", err_sticky, err_rd); else passes++;
        drive_idle();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_sticky !== 1'b0) $display("FAIL err_cleared: got %b want 0", err_sticky); else passes++;
        in_valid = 1'b1; in_error = 1'b1; in_wen = 1'b1; in_rd = 5'd11;
        tick();
        checks++; if (err_sticky !== 1'b1 || err_rd !== 5'd11) $display("FAIL err_after_clear: got %b/%0d want 1/11", err_sticky, err_rd); else passes++;
        in_valid = 1'b1; in_error = 1'b0; in_wen = 1'b0; in_rd = 5'd4; in_res = 64'h44;
        tick();
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0) $display("FAIL discard_nowen: got count %0d valid %b want 0/0", count, wb_valid); else passes++;
        drive_idle();
    endtask

    task automatic test_hazard();
        wb_ready = 1'b0;
        push_in(64'h66, 5'd6);
        tick();
        drive_idle();
        hz_rd = 5'd6;
        #1;
        checks++; if (hz_hit !== 1'b1) $display("FAIL hz_queued: got %b want 1", hz_hit); else passes++;
        hz_rd = 5'd2;
        #1;
        checks++; if (hz_hit !== 1'b0) $display("FAIL hz_other: got %b want 0", hz_hit); else passes++;
        hz_rd = 5'd6;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || hz_hit !== 1'b0) $display("FAIL hz_after_pop: got count %0d hit %b want 0/0", count, hz_hit); else passes++;
        push_in(64'h22, 5'd2);
        tick();
        drive_idle();
        #1;
        checks++; if (hz_hit !== 1'b0) $display("FAIL hz_stale_slot: got %b want 0", hz_hit); else passes++;
        hz_rd = 5'd2;
        #1;
        checks++; if (hz_hit !== 1'b1) $display("FAIL hz_new_entry: got %b want 1", hz_hit); else passes++;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        hz_rd = '0;
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b0;
        push_in(64'hB0, 5'd10);
        tick();
        push_in(64'hB1, 5'd11);
        tick();
        checks++; if (count !== 3'd2) $display("FAIL b2b_prefill: got %0d want 2", count); else passes++;
        for (int k = 0; k < 10; k++) begin
            push_in(64'hB2 + 64'(k), 5'(12 + k));
            wb_ready = 1'b1;
            #1;
            checks++; if (wb_data !== 64'hB0 + 64'(k) || wb_rd !== 5'(10 + k)) $display("FAIL b2b_head: got %h/%0d want %h/%0d", wb_data, wb_rd, 64'hB0 + 64'(k), 10 + k); else passes++;
            tick();
            checks++; if (count !== 3'd2) $display("FAIL b2b_count: got %0d want 2", count); else passes++;
        end
        drive_idle();
        #1;
        for (int k = 10; k < 12; k++) begin
            checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hB0 + 64'(k) || wb_rd !== 5'(10 + k)) $display("FAIL b2b_tail: got %b/%h/%0d want 1/%h/%0d", wb_valid, wb_data, wb_rd, 64'hB0 + 64'(k), 10 + k); else passes++;
            tick();
        end
        checks++; if (count !== 3'd0) $display("FAIL b2b_drained: got %0d want 0", count); else passes++;
        wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            push_in(64'h300 + 64'(i), 5'(i));
            tick();
        end
        drive_idle();
        checks++; if (count !== 3'd3) $display("FAIL rstmid_prefill: got %0d want 3", count); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (wb_valid !== 1'b0 || count !== 3'd0) $display("FAIL rstmid_async: got valid %b count %0d want 0/0", wb_valid, count); else passes++;
        tick();
        rst = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wb_valid !== 1'b0 || count !== 3'd0) $display("FAIL rstmid_no_wb: got valid %b count %0d want 0/0", wb_valid, count); else passes++;
        end
        wb_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_error();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
